// File: rtl/control_sequencer.sv
// control_sequencer
//   Moore control sequencer for the register-select stage. Each instruction
//   steps through fetch (T0-T2) and execute (T3-T7); HALT is terminal until
//   clear. Strobes decode from state and IR only.
//
//   state | meaning
//   T0    | PC -> MAR, PC+1 -> Z
//   T1    | Z -> PC (first cycle only), memory read, wait mem_ready
//   T2    | MDR -> IR
//   T3    | execute step 1 / opcode dispatch
//   T4    | ALU operation into Z
//   T5    | Z -> Ra (ALU forms) or Z -> MAR (ld/st)
//   T6    | ld: read wait / st: Ra -> MDR
//   T7    | ld: MDR -> Ra / st: write wait
//   HALT  | stopped, run=0
//
// Ports:
//   clock, clear          rising-edge clock, async active-high reset
//   IR[31:0]              instruction register (opcode in IR[31:27])
//   mem_ready             memory finished current Read/Write
//   PCout..BAout          datapath and register-select strobes
//   alu_op[ALUW-1:0]      ALU operation, meaningful only while Zin=1
//   run                   0 once halted
//   illegal               T3 pulse for unsupported opcode
module control_sequencer #(
    parameter int OPW  = 5,
    parameter int ALUW = 5
) (
    input  logic            clock,
    input  logic            clear,
    input  logic [31:0]     IR,
    input  logic            mem_ready,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPC,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            Read,
    output logic            Write,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Zlowout,
    output logic            Cout,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic [ALUW-1:0] alu_op,
    output logic            run,
    output logic            illegal
);

    localparam logic [OPW-1:0] OP_LD   = OPW'(5'b00000);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_ST   = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5'b01100);
    localparam logic [OPW-1:0] OP_ANDI = OPW'(5'b01101);
    localparam logic [OPW-1:0] OP_ORI  = OPW'(5'b01110);
    localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10100);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

    localparam logic [ALUW-1:0] ALU_ADD = ALUW'(5'b00011);
    localparam logic [ALUW-1:0] ALU_SUB = ALUW'(5'b00100);
    localparam logic [ALUW-1:0] ALU_AND = ALUW'(5'b00101);
    localparam logic [ALUW-1:0] ALU_OR  = ALUW'(5'b00110);

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_t1_first;

    logic [OPW-1:0]  w_op;
    logic            w_rrr, w_imm, w_mem, w_ld, w_st;
    logic [ALUW-1:0] w_alu;
    logic            w_unused_ir;

    assign w_op        = IR[31 -: OPW];
    assign w_unused_ir = ^IR[31-OPW:0];

    assign w_ld  = (w_op == OP_LD);
    assign w_st  = (w_op == OP_ST);
    assign w_mem = w_ld || w_st;
    assign w_rrr = (w_op == OP_ADD) || (w_op == OP_SUB) ||
                   (w_op == OP_AND) || (w_op == OP_OR);
    assign w_imm = (w_op == OP_ADDI) || (w_op == OP_ANDI) || (w_op == OP_ORI);

    always_comb begin
        w_alu = ALU_ADD;
        case (w_op)
            OP_SUB:          w_alu = ALU_SUB;
            OP_AND, OP_ANDI: w_alu = ALU_AND;
            OP_OR,  OP_ORI:  w_alu = ALU_OR;
            default:         w_alu = ALU_ADD;
        endcase
    end

    // Set on the T0->T1 transition so PCin fires only in the first T1 cycle
    // even when the read waits.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state    <= S_T0;
            r_t1_first <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_t1_first <= (r_state == S_T0);
        end
    end

    always_comb begin
        w_next  = r_state;
        PCout   = 1'b0; PCin    = 1'b0; IncPC   = 1'b0; MARin  = 1'b0;
        MDRin   = 1'b0; MDRout  = 1'b0; Read    = 1'b0; Write  = 1'b0;
        IRin    = 1'b0; Yin     = 1'b0; Zin     = 1'b0; Zlowout = 1'b0;
        Cout    = 1'b0; Gra     = 1'b0; Grb     = 1'b0; Grc    = 1'b0;
        Rin     = 1'b0; Rout    = 1'b0; BAout   = 1'b0;
        alu_op  = '0;
        illegal = 1'b0;
        run     = (r_state != S_HALT);

        case (r_state)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
                Zin = 1'b1; alu_op = ALU_ADD;
                w_next = S_T1;
            end
            S_T1: begin
                Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
                PCin = r_t1_first;
                if (mem_ready) w_next = S_T2;
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
                w_next = S_T3;
            end
            S_T3: begin
                if (w_rrr || w_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    w_next = S_T4;
                end else if (w_mem || w_op == OP_LDI) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    w_next = S_T4;
                end else if (w_op == OP_JR) begin
                    Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                    w_next = S_T0;
                end else if (w_op == OP_HALT) begin
                    w_next = S_HALT;
                end else begin
                    illegal = (w_op != OP_NOP);
                    w_next  = S_T0;
                end
            end
            S_T4: begin
                Zin = 1'b1;
                alu_op = w_alu;
                if (w_rrr) begin
                    Grc = 1'b1; Rout = 1'b1;
                end else begin
                    Cout = 1'b1;
                end
                w_next = S_T5;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (w_mem) begin
                    MARin  = 1'b1;
                    w_next = S_T6;
                end else begin
                    Gra = 1'b1; Rin = 1'b1;
                    w_next = S_T0;
                end
            end
            S_T6: begin
                if (w_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    w_next = S_T7;
                end else begin
                    Read = 1'b1; MDRin = 1'b1;
                    if (mem_ready) w_next = S_T7;
                end
            end
            S_T7: begin
                if (w_st) begin
                    Write = 1'b1;
                    if (mem_ready) w_next = S_T0;
                end else begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    w_next = S_T0;
                end
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_T0;
        endcase

        // clear forces quiet outputs the same cycle, including a pending Read/Write.
        if (clear) begin
            PCout   = 1'b0; PCin    = 1'b0; IncPC   = 1'b0; MARin  = 1'b0;
            MDRin   = 1'b0; MDRout  = 1'b0; Read    = 1'b0; Write  = 1'b0;
            IRin    = 1'b0; Yin     = 1'b0; Zin     = 1'b0; Zlowout = 1'b0;
            Cout    = 1'b0; Gra     = 1'b0; Grb     = 1'b0; Grc    = 1'b0;
            Rin     = 1'b0; Rout    = 1'b0; BAout   = 1'b0;
            alu_op  = '0;
            illegal = 1'b0;
            run     = 1'b1;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] IR;
    logic        mem_ready;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, Zin;
    logic Zlowout, Cout, Gra, Grb, Grc, Rin, Rout, BAout, run, illegal;
    logic [4:0] alu_op;

    control_sequencer #(.OPW(5), .ALUW(5)) dut (
        .clock(clock), .clear(clear), .IR(IR), .mem_ready(mem_ready),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
        .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .alu_op(alu_op), .run(run), .illegal(illegal)
    );

    always #5 clock = ~clock;

    // Packed output vector layout (bit positions).
    localparam logic [25:0] PCOUT = 26'd1 << 25, PCIN  = 26'd1 << 24;
    localparam logic [25:0] INCPC = 26'd1 << 23, MARIN = 26'd1 << 22;
    localparam logic [25:0] MDRIN = 26'd1 << 21, MDROUT = 26'd1 << 20;
    localparam logic [25:0] READ  = 26'd1 << 19, WRITE = 26'd1 << 18;
    localparam logic [25:0] IRIN  = 26'd1 << 17, YIN   = 26'd1 << 16;
    localparam logic [25:0] ZIN   = 26'd1 << 15, ZLOW  = 26'd1 << 14;
    localparam logic [25:0] COUT  = 26'd1 << 13, GRA   = 26'd1 << 12;
    localparam logic [25:0] GRB   = 26'd1 << 11, GRC   = 26'd1 << 10;
    localparam logic [25:0] RIN   = 26'd1 << 9,  ROUT  = 26'd1 << 8;
    localparam logic [25:0] BAOUT = 26'd1 << 7,  RUN   = 26'd1 << 6;
    localparam logic [25:0] ILL   = 26'd1 << 5;
    localparam logic [25:0] A_ADD = 26'd3, A_SUB = 26'd4, A_AND = 26'd5, A_OR = 26'd6;

    localparam logic [25:0] E_RST = RUN;
    localparam logic [25:0] E_T0  = PCOUT | MARIN | INCPC | ZIN | RUN | A_ADD;
    localparam logic [25:0] E_T1F = ZLOW | PCIN | READ | MDRIN | RUN;
    localparam logic [25:0] E_T1W = ZLOW | READ | MDRIN | RUN;
    localparam logic [25:0] E_T2  = MDROUT | IRIN | RUN;

    wire [25:0] w_act = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write,
                         IRin, Yin, Zin, Zlowout, Cout, Gra, Grb, Grc, Rin,
                         Rout, BAout, run, illegal, alu_op};

    logic [25:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    logic [25:0] m_exp, m_mask;

    // Monitor: one expected vector per cycle, compared mid-cycle. alu_op
    // is only checked where Zin is expected.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            m_exp  = exp_q.pop_front();
            m_mask = (m_exp & ZIN) != 0 ? 26'h3ffffff : 26'h3ffffe0;
            n_vec++;
            if ((w_act & m_mask) !== (m_exp & m_mask)) begin
                n_err++;
                $display("FAIL vec%0d t=%0t outputs act=%h exp=%h", n_vec, $time,
                         w_act & m_mask, m_exp & m_mask);
            end
        end
    end

    task automatic step(input logic [25:0] e, input logic mr);
        @(posedge clock);
        #1;
        mem_ready = mr;
        exp_q.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] ir, input int t1wait);
        step(E_T0, 1'b1);
        clear = 1'b0;
        IR    = ir;
        step(E_T1F, t1wait == 0);
        for (int i = 0; i < t1wait; i++) step(E_T1W, i == t1wait - 1);
        step(E_T2, 1'b1);
    endtask

    task automatic alu_instr(input logic [31:0] ir, input logic [25:0] aop,
                             input logic imm, input int t1wait);
        fetch(ir, t1wait);
        step(GRB | ROUT | YIN | RUN, 1'b1);
        step((imm ? COUT : (GRC | ROUT)) | ZIN | RUN | aop, 1'b1);
        step(ZLOW | GRA | RIN | RUN, 1'b1);
    endtask

    task automatic addr_calc(input logic [31:0] ir);
        fetch(ir, 0);
        step(GRB | BAOUT | YIN | RUN, 1'b1);
        step(COUT | ZIN | RUN | A_ADD, 1'b1);
    endtask

    task automatic ld_instr(input logic [31:0] ir, input int t6wait);
        addr_calc(ir);
        step(ZLOW | MARIN | RUN, 1'b0);
        step(READ | MDRIN | RUN, t6wait == 0);
        for (int i = 0; i < t6wait; i++) step(READ | MDRIN | RUN, i == t6wait - 1);
        step(MDROUT | GRA | RIN | RUN, 1'b1);
    endtask

    task automatic st_instr(input logic [31:0] ir, input int t7wait);
        addr_calc(ir);
        step(ZLOW | MARIN | RUN, 1'b1);
        step(GRA | ROUT | MDRIN | RUN, 1'b0);
        step(WRITE | RUN, t7wait == 0);
        for (int i = 0; i < t7wait; i++) step(WRITE | RUN, i == t7wait - 1);
    endtask

    initial begin
        clear = 1'b1;
        IR = 32'h0;
        mem_ready = 1'b0;

        step(E_RST, 1'b1);
        step(E_RST, 1'b0);

        alu_instr(32'h18918000, A_ADD, 1'b0, 0);
        alu_instr(32'h20918000, A_SUB, 1'b0, 2);
        alu_instr(32'h28918000, A_AND, 1'b0, 0);
        alu_instr(32'h30918000, A_OR,  1'b0, 0);
        alu_instr(32'h60918005, A_ADD, 1'b1, 0);
        alu_instr(32'h68918005, A_AND, 1'b1, 1);
        alu_instr(32'h70918005, A_OR,  1'b1, 0);

        addr_calc(32'h08000010);
        step(ZLOW | GRA | RIN | RUN, 1'b1);

        ld_instr(32'h02000010, 3);
        ld_instr(32'h02000010, 0);
        st_instr(32'h12B00020, 2);
        st_instr(32'h12B00020, 0);

        fetch(32'hA0800000, 0);
        step(GRA | ROUT | PCIN | RUN, 1'b1);

        fetch(32'hD0000000, 0);
        step(RUN, 1'b1);

        fetch(32'hF8000000, 0);
        step(RUN | ILL, 1'b1);

        // clear asserted in the middle of T4 of an add
        fetch(32'h18918000, 0);
        step(GRB | ROUT | YIN | RUN, 1'b1);
        step(GRC | ROUT | ZIN | RUN | A_ADD, 1'b1);
        @(negedge clock);
        #2;
        clear = 1'b1;
        step(E_RST, 1'b1);
        step(E_RST, 1'b0);
        alu_instr(32'h18918000, A_ADD, 1'b0, 0);

        // halt, stays stopped regardless of mem_ready, then clear restarts
        fetch(32'hD8000000, 0);
        step(RUN, 1'b1);
        for (int i = 0; i < 50; i++) step(26'd0, 1'($urandom_range(0, 1)));
        step(E_RST, 1'b1);
        clear = 1'b1;
        step(E_RST, 1'b0);
        fetch(32'hD0000000, 0);
        step(RUN, 1'b1);
        step(E_T0, 1'b1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        @(negedge clock);
        if (exp_q.size() > 0) begin
            n_err++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Moore-style control sequencer that drives the register-select stage. It steps each instruction through fetch (T0-T2) and execute (T3-T7) states. In each state it asserts the Gra/Grb/Grc/Rin/Rout/BAout strobes that the select/encode stage turns into per-register enables, plus the datapath strobes. It waits on a memory ready handshake during memory steps and stops on halt.

Parameters:
OPW, 5, opcode width, taken from IR[31:27]
ALUW, 5, width of alu_op field

Ports:
clock  input  1  system clock, rising edge
clear  input  1  asynchronous active-high reset
IR  input  32  current instruction register contents
mem_ready  input  1  memory completed the requested Read/Write this cycle
PCout, PCin, IncPC  output  1 each  program counter strobes
MARin, MDRin, MDRout, Read, Write  output  1 each  memory interface strobes
IRin, Yin, Zin, Zlowout, Cout  output  1 each  IR/ALU/immediate strobes
Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register-select strobes
alu_op  output  ALUW  ALU operation; valid only when Zin=1
run  output  1  1 while executing; 0 after halt
illegal  output  1  one-cycle pulse at T3 for an unsupported opcode

Behaviour:
- Opcodes (IR[31:27]): ld=00000, ldi=00001, st=00010, add=00011, sub=00100, and=00101, or=00110, addi=01100, andi=01101, ori=01110, jr=10100, nop=11010, halt=11011. All other opcodes are unsupported.
- alu_op encodes the ALU operation: ADD=00011, SUB=00100, AND=00101, OR=00110. Immediate forms map to ADD/AND/OR.
- States: T0, T1, T2, T3, T4, T5, T6, T7, HALT. State is registered; all outputs decode from state and IR only, with no registered outputs.
- While clear=1: state=T0, run=1, and every other output is 0. When clear is released, T0 is active on the first clock.
- Reset mid-operation: clear forces T0 immediately, aborting the instruction. Any pending Read/Write drops the same cycle.
- Fetch sequence:
  - T0: PCout, MARin, IncPC, Zin (alu_op=ADD).
  - T1: Zlowout, PCin, Read, MDRin. Hold T1 until mem_ready=1; PCin is asserted only in the first T1 cycle.
  - T2: MDRout, IRin.
- add/sub/and/or:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op per opcode.
  - T5: Zlowout, Gra, Rin. Then T0.
- addi/andi/ori:
  - T3: Grb, Rout, Yin.
  - T4: Cout, Zin, alu_op per opcode.
  - T5: Zlowout, Gra, Rin. Then T0.
- ldi:
  - T3: Grb, BAout, Yin.
  - T4: Cout, Zin, ADD.
  - T5: Zlowout, Gra, Rin. Then T0.
- ld:
  - T3-T4 as ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin; hold until mem_ready.
  - T7: MDRout, Gra, Rin. Then T0.
- st:
  - T3-T5 as ld.
  - T6: Gra, Rout, MDRin.
  - T7: Write; hold until mem_ready. Then T0.
- jr: T3: Gra, Rout, PCin. Then T0.
- nop: T3 with all outputs 0, then T0.
- Unsupported opcode: behaves as nop, and illegal=1 during T3.
- halt: T3 goes to HALT. In HALT, run=0 and all strobes are 0. HALT is left only via clear.
- Select-strobe exclusivity: at most one of Gra/Grb/Grc is 1 in any cycle, and Rin is never asserted together with Rout or BAout.
- mem_ready outside T1/T6(ld)/T7(st) is ignored. If mem_ready is already high on entry to a wait state, the wait lasts exactly one cycle.
- Latency with zero wait states:
  - ALU/immediate/ldi: 6 cycles.
  - ld/st: 8 cycles.
  - jr/nop: 4 cycles.
  - Each memory wait cycle adds 1.

Test Plan:
- Reset: assert clear mid-T4 of an add -> the same cycle all strobes are 0; after release, T0 asserts PCout=MARin=IncPC=Zin=1 with alu_op=00011.
- add R1,R2,R3 (IR=0x18918000), mem_ready always 1 -> T3 Grb+Rout+Yin, T4 Grc+Rout+Zin with alu_op=00011, T5 Gra+Rin; next T0 six cycles after the first T0.
- ld R4,0x10(R0) (IR=0x02000010), mem_ready delayed 3 cycles in T6 -> Read+MDRin held 4 cycles; T7 Gra+Rin; total 11 cycles.
- st R5,0x20(R6) (IR=0x12B00020) -> T3 Grb+BAout+Yin, T6 Gra+Rout+MDRin, T7 Write held until mem_ready; Rin never asserted.
- Opcode 11111 -> illegal=1 for exactly one cycle in T3, no register strobes, then T0.
- halt (IR=0xD8000000) -> run falls after T3 and stays 0 for 50 cycles regardless of mem_ready; clear returns to T0 with run=1.
